f2f_issue_scheduler: RTL and testbench
======================================

// Module: f2f_issue_scheduler
// PURPOSE
//  Shares one float->fixed conversion pipeline (32-bit float in, fixed_integer/fixed_fraction out)
//  between NUM_REQ requesters. Round-robin arbitration, a tag shift register tracking in-flight
//  requester IDs, and a response FIFO with credit-based issue. No result is ever dropped, and the
//  pipeline is never stalled. Sits between the request fabric and the converter instance.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2)
//  INT_WID    16  converter integer width
//  FRA_WID    16  converter fraction width
//  PIPE_LAT   5   clock edges from the edge that samples pipe_float_val to valid converter outputs
//  RSP_DEPTH  8   response FIFO depth; must be >= PIPE_LAT
//  CNT_WID    16  exception counter width
//  (local) ID_WID = $clog2(NUM_REQ)
// PORTS
//  clk            in   1                clock
//  rst            in   1                synchronous reset, active-high
//  req_valid      in   NUM_REQ          per-requester request valid
//  req_ready      out  NUM_REQ          per-requester accept (one-hot or zero)
//  req_float      in   NUM_REQ*32       requester i operand in bits [32*i+:32]
//  pipe_clk_en    out  1                converter clock enable
//  pipe_float_val out  32               operand to converter
//  pipe_integer   in   INT_WID          converter fixed_integer
//  pipe_fraction  in   FRA_WID          converter fixed_fraction
//  pipe_flags     in   6                {overflow,underflow,nan,infinity,denorm,zero}
//  rsp_valid      out  1                response valid
//  rsp_ready      in   1                response accept
//  rsp_id         out  ID_WID           originating requester
//  rsp_integer    out  INT_WID          result integer part
//  rsp_fraction   out  FRA_WID          result fraction part
//  rsp_flags      out  6                flags, same order as pipe_flags
//  busy           out  1                any tag in flight or FIFO non-empty
//  exc_clr        in   1                clear exception counter
//  exc_count      out  CNT_WID          saturating count of excepted results
// BEHAVIOUR
//  Reset (rst=1 at an edge): req_ready=0, rsp_valid=0, busy=0, exc_count=0, rr_ptr=0, credit=0,
//   all tag valids=0, FIFO empty. pipe_clk_en=~rst (combinational). pipe_float_val=0.
//   A reset mid-operation discards all in-flight and queued results; converter outputs are ignored
//   until new tags reach the tail.
//  Credit: credit = in-flight tags + FIFO entries. +1 on issue, -1 on rsp handshake; both in the
//   same cycle -> unchanged. Issue is allowed iff credit < RSP_DEPTH (registered value). A pop does
//   not free a slot in the same cycle. The FIFO therefore never overflows.
//  Arbitration: grant = first i with req_valid[i], searching from rr_ptr upward and wrapping.
//   req_ready[grant] = issue_ok; all other bits are 0. req_ready may depend on req_valid.
//   On issue (req_valid&req_ready), rr_ptr <= (grant+1) mod NUM_REQ; otherwise rr_ptr holds.
//  Issue: pipe_float_val = req_float[grant] combinationally when issuing, else 0.
//   Tag stage 0 <= {1, grant} on issue, {0, x} otherwise. The tag register shifts every cycle.
//  Latency: request accepted at edge k -> tag at stage PIPE_LAT-1 after edge k+PIPE_LAT-1, the same
//   cycle the converter outputs are valid -> FIFO push at edge k+PIPE_LAT -> rsp_valid is 1 in the
//   following cycle (earliest). Full throughput: one issue per cycle while credit is available.
//  FIFO: push {id, integer, fraction, flags} when the tail tag is valid. Pop on rsp_valid&rsp_ready.
//   rsp_* is driven from the FIFO head and held stable while rsp_valid&!rsp_ready.
//   Push on full is impossible by credit. Push and pop in the same cycle is legal at any occupancy.
//   Pointers wrap modulo RSP_DEPTH (non-power-of-2 supported).
//  exc_count: +1 per FIFO push with any of overflow/underflow/nan/infinity set; saturates at all-ones.
//   exc_clr together with an increment -> 0 (clear wins).
//  busy = |tag valids | (FIFO count != 0).
//  The converter must honour pipe_clk_en in every stage. The scheduler holds pipe_clk_en=1 whenever
//   not in reset and relies solely on PIPE_LAT. The converter's own done output is not used.
// STRUCTURE
//  Package f2f_pkg: flag bit indices (F_OVF=5, F_UDF=4, F_NAN=3, F_INF=2, F_DEN=1, F_ZERO=0),
//   FLAG_WID=6, and the response record width helper (ID_WID+INT_WID+FRA_WID+FLAG_WID).
//  Sub-module f2f_rsp_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with push/pop/count/empty.
//  Arbiter, tag shift register, credit counter and exception counter live in this module.
// TESTING
//  1 Single request, req 2 sends 0x41200000 (10.0), INT/FRA=16 -> rsp_valid in cycle k+6,
//    rsp_id=2, integer=10, fraction=0, flags=0, exc_count=0.
//  2 All 4 requests held valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 in order, one per cycle;
//    responses return in issue order.
//  3 rsp_ready=0, req 0 streaming -> exactly RSP_DEPTH=8 issues, then req_ready=0. Raise rsp_ready
//    -> one response per cycle and no loss; issue resumes one cycle after the first pop.
//  4 Operands 0x7F800000 (inf), 0x7FC00000 (nan), 0x47800000 (65536.0) -> flags carry inf/nan/ovf,
//    exc_count=3. exc_clr asserted together with the 4th excepted push -> exc_count=0.
//  5 Assert rst with 3 tags in flight and 2 queued -> next cycle rsp_valid=0, busy=0, credit=0;
//    no stale response ever appears afterwards.
//  6 Random valid/ready over 10k cycles vs. a scoreboard -> per-requester result order preserved,
//    no drops, and req_ready is never 1 while credit==RSP_DEPTH.

Source files
------------

// File: rtl/f2f_pkg.sv
// Shared constants for the float->fixed issue scheduler: flag bit positions and
// the width of one queued response record.
package f2f_pkg;

  localparam int unsigned FLAG_WID = 6;

  localparam int unsigned F_OVF  = 5;
  localparam int unsigned F_UDF  = 4;
  localparam int unsigned F_NAN  = 3;
  localparam int unsigned F_INF  = 2;
  localparam int unsigned F_DEN  = 1;
  localparam int unsigned F_ZERO = 0;

  // Response record layout is {id, integer, fraction, flags}, MSB first.
  function automatic int unsigned rsp_rec_wid(input int unsigned id_wid,
                                              input int unsigned int_wid,
                                              input int unsigned fra_wid);
    return id_wid + int_wid + fra_wid + FLAG_WID;
  endfunction

endpackage

// File: rtl/f2f_rsp_fifo.sv
// Synchronous FIFO holding converter results until the response side accepts them.
// Depth need not be a power of two; pointers wrap explicitly.
module f2f_rsp_fifo #(
  parameter int unsigned  WIDTH   = 40,
  parameter int unsigned  DEPTH   = 8,
  localparam int unsigned PTR_WID = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_WID = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic [CNT_WID-1:0] count,
  output logic               empty
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_WID-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WID-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WID-1:0] count_q, count_d;
  logic               full;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PTR_WID-1:0] ptr_inc(input logic [PTR_WID-1:0] ptr);
    return (ptr == PTR_WID'(DEPTH - 1)) ? '0 : ptr + PTR_WID'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_WID'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop frees the head slot in the same edge, so push-on-full is fine alongside it.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_WID'(do_push) - CNT_WID'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/f2f_issue_scheduler.sv
// Shares one fixed-latency float->fixed converter between NUM_REQ requesters using
// round-robin issue, a tag shift register and a credit-guarded response FIFO.
module f2f_issue_scheduler
  import f2f_pkg::*;
#(
  parameter int unsigned  NUM_REQ   = 4,
  parameter int unsigned  INT_WID   = 16,
  parameter int unsigned  FRA_WID   = 16,
  parameter int unsigned  PIPE_LAT  = 5,
  parameter int unsigned  RSP_DEPTH = 8,
  parameter int unsigned  CNT_WID   = 16,
  localparam int unsigned ID_WID    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_float,
  output logic                    pipe_clk_en,
  output logic [31:0]             pipe_float_val,
  input  logic [INT_WID-1:0]      pipe_integer,
  input  logic [FRA_WID-1:0]      pipe_fraction,
  input  logic [FLAG_WID-1:0]     pipe_flags,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_WID-1:0]       rsp_id,
  output logic [INT_WID-1:0]      rsp_integer,
  output logic [FRA_WID-1:0]      rsp_fraction,
  output logic [FLAG_WID-1:0]     rsp_flags,
  output logic                    busy,
  input  logic                    exc_clr,
  output logic [CNT_WID-1:0]      exc_count
);

  localparam int unsigned REC_WID = rsp_rec_wid(ID_WID, INT_WID, FRA_WID);
  localparam int unsigned CRD_WID = $clog2(RSP_DEPTH + 1);

  logic [ID_WID-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CRD_WID-1:0] credit_q, credit_d;
  logic [CNT_WID-1:0] exc_q, exc_d;
  logic [PIPE_LAT-1:0] tag_vld_q;
  logic [ID_WID-1:0]  tag_id_q [PIPE_LAT];

  logic [ID_WID-1:0]  grant;
  logic [ID_WID-1:0]  cand;
  logic               any_valid;
  logic               issue_ok;
  logic               issue;
  logic               push;
  logic               pop;
  logic               exc_hit;
  logic [REC_WID-1:0] push_rec;
  logic [REC_WID-1:0] head_rec;
  logic [CRD_WID-1:0] fifo_count;
  logic               fifo_empty;

  // Credit covers both in-flight tags and queued entries, so a full credit means
  // every FIFO slot is already spoken for and the pipe never needs to stall.
  assign issue_ok = (credit_q < CRD_WID'(RSP_DEPTH));

  always_comb begin
    grant     = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = ID_WID'((32'(rr_ptr_q) + off) % NUM_REQ);
      if (!any_valid && req_valid[cand]) begin
        grant     = cand;
        any_valid = 1'b1;
      end
    end
  end

  assign issue = any_valid && issue_ok && !rst;

  always_comb begin
    req_ready = '0;
    if (issue) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign pipe_clk_en    = ~rst;
  assign pipe_float_val = issue ? req_float[32*grant +: 32] : 32'h0;

  // Tag stage PIPE_LAT-1 lines up with valid converter outputs.
  assign push     = tag_vld_q[PIPE_LAT-1];
  assign push_rec = {tag_id_q[PIPE_LAT-1], pipe_integer, pipe_fraction, pipe_flags};
  assign exc_hit  = push && (pipe_flags[F_OVF] || pipe_flags[F_UDF] ||
                             pipe_flags[F_NAN] || pipe_flags[F_INF]);

  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign {rsp_id, rsp_integer, rsp_fraction, rsp_flags} = head_rec;

  assign busy      = (|tag_vld_q) || (fifo_count != '0);
  assign exc_count = exc_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (grant == ID_WID'(NUM_REQ - 1)) ? '0 : grant + ID_WID'(1);
    end
    credit_d = credit_q + CRD_WID'(issue) - CRD_WID'(pop);
    exc_d    = exc_q;
    if (exc_clr) begin
      exc_d = '0;
    end else if (exc_hit && (exc_q != '1)) begin
      exc_d = exc_q + CNT_WID'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      credit_q <= '0;
      exc_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      exc_q    <= exc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        tag_id_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= issue;
      tag_id_q[0]  <= grant;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  f2f_rsp_fifo #(
    .WIDTH (REC_WID),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head_rec),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_f2f_issue_scheduler.sv
// Directed and randomised checks of f2f_issue_scheduler against a behavioural
// 5-stage float->Q15.16 converter.
module tb_f2f_issue_scheduler;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned INT_WID   = 16;
  localparam int unsigned FRA_WID   = 16;
  localparam int unsigned PIPE_LAT  = 5;
  localparam int unsigned RSP_DEPTH = 8;
  localparam int unsigned CNT_WID   = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_float;
  logic         pipe_clk_en;
  logic [31:0]  pipe_float_val;
  logic [15:0]  pipe_integer;
  logic [15:0]  pipe_fraction;
  logic [5:0]   pipe_flags;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [15:0]  rsp_integer;
  logic [15:0]  rsp_fraction;
  logic [5:0]   rsp_flags;
  logic         busy;
  logic         exc_clr;
  logic [15:0]  exc_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  f2f_issue_scheduler #(
    .NUM_REQ   (NUM_REQ),
    .INT_WID   (INT_WID),
    .FRA_WID   (FRA_WID),
    .PIPE_LAT  (PIPE_LAT),
    .RSP_DEPTH (RSP_DEPTH),
    .CNT_WID   (CNT_WID)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_float      (req_float),
    .pipe_clk_en    (pipe_clk_en),
    .pipe_float_val (pipe_float_val),
    .pipe_integer   (pipe_integer),
    .pipe_fraction  (pipe_fraction),
    .pipe_flags     (pipe_flags),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_integer    (rsp_integer),
    .rsp_fraction   (rsp_fraction),
    .rsp_flags      (rsp_flags),
    .busy           (busy),
    .exc_clr        (exc_clr),
    .exc_count      (exc_count)
  );

  // Float -> signed Q15.16 plus flags {ovf,udf,nan,inf,den,zero}.
  function automatic logic [37:0] conv(input logic [31:0] f);
    int          e;
    longint      v;
    logic [5:0]  fl;
    logic [31:0] fx;
    e  = int'(f[30:23]);
    fl = '0;
    fx = '0;
    v  = longint'({1'b1, f[22:0]});
    if (e == 255) begin
      if (f[22:0] != 0) fl[3] = 1'b1;
      else begin
        fl[2] = 1'b1;
        fx = f[31] ? 32'h8000_0000 : 32'h7fff_ffff;
      end
    end else if (e == 0) begin
      if (f[22:0] == 0) fl[0] = 1'b1;
      else begin
        fl[1] = 1'b1;
        fl[4] = 1'b1;
      end
    end else if (e >= 142) begin
      fl[5] = 1'b1;
      fx = f[31] ? 32'h8000_0000 : 32'h7fff_ffff;
    end else if (e < 111) begin
      fl[4] = 1'b1;
    end else begin
      if (e >= 134) v = v <<< (e - 134);
      else v = v >>> (134 - e);
      if (f[31]) v = -v;
      fx = v[31:0];
    end
    return {fx, fl};
  endfunction

  // Exact single-precision encoding of a small positive integer.
  function automatic logic [31:0] fl_of(input int n);
    int          e;
    logic [31:0] m;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  logic [37:0] cv_q [PIPE_LAT];
  always @(posedge clk) begin
    if (pipe_clk_en) begin
      cv_q[0] <= conv(pipe_float_val);
      for (int i = 1; i < PIPE_LAT; i++) cv_q[i] <= cv_q[i-1];
    end
  end
  assign {pipe_integer, pipe_fraction, pipe_flags} = cv_q[PIPE_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_float = '0;
    rsp_ready = 1'b0;
    exc_clr   = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 4'hf;
    req_float = {4{32'h3f80_0000}};
    rsp_ready = 1'b1;
    exc_clr   = 1'b0;
    repeat (2) tick();
    n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    n_cmp++; if (pipe_clk_en !== 1'b0) begin n_bad++; $display("FAIL reset_clk_en got=%b want=0", pipe_clk_en); end
    n_cmp++; if (pipe_float_val !== 32'h0) begin n_bad++; $display("FAIL reset_float_val got=%h want=0", pipe_float_val); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (exc_count !== 16'h0) begin n_bad++; $display("FAIL reset_exc_count got=%0d want=0", exc_count); end
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if (pipe_clk_en !== 1'b1) begin n_bad++; $display("FAIL run_clk_en got=%b want=1", pipe_clk_en); end
  endtask

  task automatic test_single();
    req_valid         = 4'b0100;
    req_float[95:64]  = 32'h4120_0000;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready got=%b want=0100", req_ready); end
    n_cmp++; if (pipe_float_val !== 32'h4120_0000) begin n_bad++; $display("FAIL single_float got=%h want=41200000", pipe_float_val); end
    tick();
    req_valid = '0;
    for (int n = 1; n < 5; n++) begin
      tick();
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid edge=k+%0d got=%b want=0", n, rsp_valid); end
    end
    tick();
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency got=%b want=1", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL single_id got=%0d want=2", rsp_id); end
    n_cmp++; if (rsp_integer !== 16'd10) begin n_bad++; $display("FAIL single_integer got=%0d want=10", rsp_integer); end
    n_cmp++; if (rsp_fraction !== 16'd0) begin n_bad++; $display("FAIL single_fraction got=%h want=0", rsp_fraction); end
    n_cmp++; if (rsp_flags !== 6'd0) begin n_bad++; $display("FAIL single_flags got=%b want=000000", rsp_flags); end
    n_cmp++; if (exc_count !== 16'd0) begin n_bad++; $display("FAIL single_exc got=%0d want=0", exc_count); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got=%b want=1", busy); end
    rsp_ready = 1'b1;
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop_valid got=%b want=0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got=%b want=0", busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int         got;
    logic [3:0] exp_rdy;
    do_reset();
    rsp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      if (cyc < 8) begin
        req_valid = 4'hf;
        req_float = {4{fl_of(cyc + 1)}};
      end else begin
        req_valid = '0;
      end
      #1;
      if (cyc < 8) begin
        exp_rdy = 4'b0001 << (cyc % 4);
        n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy); end
      end
      if (rsp_valid) begin
        n_cmp++;
        if (rsp_id !== 2'(got % 4) || rsp_integer !== 16'(got + 1)) begin
          n_bad++;
          $display("FAIL rr_order rsp=%0d got id=%0d int=%0d want id=%0d int=%0d", got, rsp_id, rsp_integer, got % 4, got + 1);
        end
        got++;
      end
      tick();
    end
    n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL rr_count got=%0d want=8", got); end
  endtask

  task automatic test_backpressure();
    int issued;
    int got;
    logic [3:0] exp_rdy;
    do_reset();
    issued           = 0;
    req_valid        = 4'b0001;
    req_float[31:0]  = fl_of(1);
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      exp_rdy = (cyc < 8) ? 4'b0001 : 4'b0000;
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL bp_fill cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy); end
      if (req_ready[0]) issued++;
      tick();
      req_float[31:0] = fl_of(issued + 1);
    end
    n_cmp++; if (issued !== 8) begin n_bad++; $display("FAIL bp_issued got=%0d want=8", issued); end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_queued got=%b want=1", rsp_valid); end
    rsp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 12; cyc++) begin
      #1;
      if (cyc == 0) begin
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_first_pop_ready got=%b want=0000", req_ready); end
      end
      if (cyc == 1) begin
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_resume_ready got=%b want=0001", req_ready); end
      end
      if (cyc < 8) begin
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_drain_rate cyc=%0d got=%b want=1", cyc, rsp_valid); end
      end
      if (rsp_valid) begin
        n_cmp++;
        if (rsp_id !== 2'd0 || rsp_integer !== 16'(got + 1)) begin
          n_bad++;
          $display("FAIL bp_order rsp=%0d got id=%0d int=%0d want id=0 int=%0d", got, rsp_id, rsp_integer, got + 1);
        end
        got++;
      end
      if (req_ready[0]) issued++;
      tick();
      req_float[31:0] = fl_of(issued + 1);
      req_valid       = (issued < 12) ? 4'b0001 : 4'b0000;
    end
    n_cmp++; if (got !== 12) begin n_bad++; $display("FAIL bp_count got=%0d want=12", got); end
  endtask

  task automatic test_exceptions();
    logic [31:0] ops [3];
    logic [5:0]  exp_fl [3];
    int got;
    ops    = '{32'h7f80_0000, 32'h7fc0_0000, 32'h4780_0000};
    exp_fl = '{6'b000100, 6'b001000, 6'b100000};
    do_reset();
    rsp_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      if (cyc < 3) begin
        req_valid        = 4'b0010;
        req_float[63:32] = ops[cyc];
      end else begin
        req_valid = '0;
      end
      #1;
      if (rsp_valid) begin
        n_cmp++;
        if (rsp_id !== 2'd1 || rsp_flags !== exp_fl[got]) begin
          n_bad++;
          $display("FAIL exc_flags rsp=%0d got id=%0d flags=%b want id=1 flags=%b", got, rsp_id, rsp_flags, exp_fl[got]);
        end
        got++;
      end
      tick();
    end
    n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL exc_rsp_count got=%0d want=3", got); end
    n_cmp++; if (exc_count !== 16'd3) begin n_bad++; $display("FAIL exc_count got=%0d want=3", exc_count); end
    req_valid        = 4'b0010;
    req_float[63:32] = 32'h7f80_0000;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL exc_wrap_grant got=%b want=0010", req_ready); end
    tick();
    req_valid = '0;
    repeat (4) tick();
    n_cmp++; if (exc_count !== 16'd3 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL exc_pre_push got cnt=%0d vld=%b want cnt=3 vld=0", exc_count, rsp_valid); end
    exc_clr = 1'b1;
    tick();
    exc_clr = 1'b0;
    n_cmp++; if (exc_count !== 16'd0) begin n_bad++; $display("FAIL exc_clear_wins got=%0d want=0", exc_count); end
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_flags !== 6'b000100) begin n_bad++; $display("FAIL exc_4th got vld=%b flags=%b want vld=1 flags=000100", rsp_valid, rsp_flags); end
    tick();
  endtask

  task automatic test_reset_midop();
    int stale;
    int issued;
    bit seen;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req_valid         = 4'b1000;
      req_float[127:96] = fl_of(c + 1);
      tick();
    end
    req_valid = '0;
    repeat (2) tick();
    n_cmp++; if (busy !== 1'b1 || rsp_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre got busy=%b vld=%b want busy=1 vld=1", busy, rsp_valid); end
    rst = 1'b1;
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rsp_valid got=%b want=0", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    rst       = 1'b0;
    rsp_ready = 1'b1;
    stale     = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (rsp_valid) stale++;
    end
    n_cmp++; if (stale !== 0) begin n_bad++; $display("FAIL mid_stale got=%0d want=0", stale); end
    rsp_ready       = 1'b0;
    req_valid       = 4'b0001;
    req_float[31:0] = fl_of(1);
    issued          = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (req_ready[0]) issued++;
      tick();
      req_float[31:0] = fl_of(issued + 1);
    end
    n_cmp++; if (issued !== 8) begin n_bad++; $display("FAIL mid_credit got=%0d issues want=8", issued); end
    req_valid = '0;
    rsp_ready = 1'b1;
    seen      = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (rsp_valid) begin
        seen = 1'b1;
        n_cmp++;
        if (rsp_id !== 2'd0 || rsp_integer !== 16'd1) begin n_bad++; $display("FAIL mid_first got id=%0d int=%0d want id=0 int=1", rsp_id, rsp_integer); end
      end
      tick();
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL mid_timeout got=no response want=response"); end
    repeat (12) tick();
  endtask

  task automatic test_random();
    logic [39:0] sb [$];
    logic [39:0] head;
    logic [37:0] cv;
    logic [3:0]  exp_rdy;
    int rr_m;
    int credit_m;
    int exc_m;
    int g;
    int idx;
    do_reset();
    rr_m     = 0;
    credit_m = 0;
    exc_m    = 0;
    for (int cyc = 0; cyc < 10040; cyc++) begin
      if (cyc < 10000) begin
        req_valid = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
          req_float[32*i +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : fl_of($urandom_range(1, 1000));
        end
        rsp_ready = (((cyc / 64) % 3) == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      end else begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
      #1;
      g = -1;
      for (int off = 0; off < 4; off++) begin
        idx = (rr_m + off) % 4;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      exp_rdy = (g >= 0 && credit_m < RSP_DEPTH) ? (4'b0001 << g) : 4'b0000;
      n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_ready cyc=%0d credit=%0d got=%b want=%b", cyc, credit_m, req_ready, exp_rdy); end
      if (rsp_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL rnd_spurious cyc=%0d got id=%0d int=%h want no response", cyc, rsp_id, rsp_integer);
        end else begin
          head = sb[0];
          if ({rsp_id, rsp_integer, rsp_fraction, rsp_flags} !== head) begin
            n_bad++;
            $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, {rsp_id, rsp_integer, rsp_fraction, rsp_flags}, head);
          end
          if (rsp_ready) begin
            void'(sb.pop_front());
            credit_m--;
            if (|head[5:2]) exc_m++;
          end
        end
      end
      if (exp_rdy != 4'b0000) begin
        cv = conv(req_float[32*g +: 32]);
        sb.push_back({2'(g), cv});
        credit_m++;
        rr_m = (g + 1) % 4;
      end
      tick();
    end
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL rnd_drops got=%0d outstanding want=0", sb.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_busy got=%b want=0", busy); end
    n_cmp++; if (exc_count !== 16'(exc_m)) begin n_bad++; $display("FAIL rnd_exc got=%0d want=%0d", exc_count, exc_m); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_exceptions();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
